// File: rtl/regressor_ctrl.sv
// regressor_ctrl: three-pass control unit for the linear-regressor datapath.
// Sequences sample passes, shared divider launches (xbar, ybar, b1), b0 load and divider timeout.
`default_nettype none

module regressor_ctrl #(
  parameter int N_SAMPLES   = 150,
  parameter int ADDR_W      = 8,
  parameter int DIV_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              div_done_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              acc_clr_o,
  output logic              acc_en_o,
  output logic [1:0]        pass_sel_o,
  output logic              div_start_o,
  output logic [1:0]        div_sel_o,
  output logic              mean_ld_o,
  output logic              b1_ld_o,
  output logic              b0_ld_o,
  output logic              busy_o,
  output logic              ready_o,
  output logic              timeout_o
);

  localparam int CNT_W = $clog2(DIV_TIMEOUT + 1);
  localparam logic [ADDR_W-1:0] C_LAST_ADDR = ADDR_W'(N_SAMPLES - 1);
  localparam logic [CNT_W-1:0]  C_CNT_LAST  = CNT_W'(DIV_TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_CLR1 = 4'd1,
    S_P1   = 4'd2,
    S_MX   = 4'd3,
    S_MXW  = 4'd4,
    S_MY   = 4'd5,
    S_MYW  = 4'd6,
    S_CLR2 = 4'd7,
    S_P2   = 4'd8,
    S_B1   = 4'd9,
    S_B1W  = 4'd10,
    S_B0   = 4'd11,
    S_CLR3 = 4'd12,
    S_P3   = 4'd13,
    S_DONE = 4'd14
  } state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               timeout_q, timeout_d;
  logic               start_q;

  logic               w_start_go;
  logic               w_wait;
  state_t             w_wait_next;

  assign w_start_go = start_i & ~start_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
      start_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
      start_q   <= start_i;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    timeout_d   = timeout_q;
    acc_clr_o   = 1'b0;
    acc_en_o    = 1'b0;
    pass_sel_o  = 2'd0;
    div_start_o = 1'b0;
    div_sel_o   = 2'd0;
    mean_ld_o   = 1'b0;
    b1_ld_o     = 1'b0;
    b0_ld_o     = 1'b0;
    ready_o     = 1'b0;
    w_wait      = 1'b0;
    w_wait_next = S_IDLE;

    case (state_q)
      S_IDLE, S_DONE: begin
        ready_o = (state_q == S_DONE);
        if (w_start_go) begin
          state_d   = S_CLR1;
          timeout_d = 1'b0;
        end
      end
      S_CLR1, S_CLR2, S_CLR3: begin
        acc_clr_o = 1'b1;
        addr_d    = '0;
        case (state_q)
          S_CLR1:  state_d = S_P1;
          S_CLR2:  state_d = S_P2;
          default: state_d = S_P3;
        endcase
      end
      S_P1, S_P2, S_P3: begin
        acc_en_o = 1'b1;
        case (state_q)
          S_P1:    pass_sel_o = 2'd0;
          S_P2:    pass_sel_o = 2'd1;
          default: pass_sel_o = 2'd2;
        endcase
        // Last sample returns addr to 0 rather than wrapping past N-1.
        if (addr_q == C_LAST_ADDR) begin
          addr_d = '0;
          case (state_q)
            S_P1:    state_d = S_MX;
            S_P2:    state_d = S_B1;
            default: state_d = S_DONE;
          endcase
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      S_MX: begin
        div_start_o = 1'b1;
        div_sel_o   = 2'd0;
        cnt_d       = '0;
        state_d     = S_MXW;
      end
      S_MXW: begin
        div_sel_o   = 2'd0;
        mean_ld_o   = div_done_i;
        w_wait      = 1'b1;
        w_wait_next = S_MY;
      end
      S_MY: begin
        div_start_o = 1'b1;
        div_sel_o   = 2'd1;
        cnt_d       = '0;
        state_d     = S_MYW;
      end
      S_MYW: begin
        div_sel_o   = 2'd1;
        mean_ld_o   = div_done_i;
        w_wait      = 1'b1;
        w_wait_next = S_CLR2;
      end
      S_B1: begin
        div_start_o = 1'b1;
        div_sel_o   = 2'd2;
        cnt_d       = '0;
        state_d     = S_B1W;
      end
      S_B1W: begin
        div_sel_o   = 2'd2;
        b1_ld_o     = div_done_i;
        w_wait      = 1'b1;
        w_wait_next = S_B0;
      end
      S_B0: begin
        b0_ld_o = 1'b1;
        state_d = S_CLR3;
      end
      default: state_d = S_IDLE;
    endcase

    // Shared divider wait: advance on done, abort to IDLE once the budget is spent.
    if (w_wait) begin
      if (div_done_i) begin
        state_d = w_wait_next;
      end else if (cnt_q == C_CNT_LAST) begin
        state_d   = S_IDLE;
        timeout_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign addr_o    = addr_q;
  assign timeout_o = timeout_q;
  assign busy_o    = (state_q != S_IDLE) && (state_q != S_DONE);

endmodule

`default_nettype wire
